modbus_resp_sched: RTL and testbench

- Scheduler and arbiter in front of the Modbus RTU response transmitter engine (ports func_code, tx_quantity, tx_data, tx_addr, tx_start, response_done).
- Two requesters share the single RS485 transmit engine:
  - the normal read-response path;
  - the exception-response path.
- The block grants one requester, muxes its frame fields onto the engine, and starts the engine with a rising edge on tx_start.
- It waits for response_done, enforces a minimum idle gap before the next start, and aborts on a watchdog timeout.

---
 rtl/modbus_resp_sched_if.sv | 27 ++
 rtl/modbus_resp_sched.sv | 163 ++++++++++++++++
 tb/tb_modbus_resp_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_resp_sched_if.sv
// Bus between the response scheduler and the Modbus RTU transmit engine.
interface modbus_resp_sched_if;
    logic        eng_tx_start;
    logic [7:0]  eng_func_code;
    logic [7:0]  eng_tx_quantity;
    logic [15:0] eng_tx_data;
    logic [7:0]  eng_tx_addr;
    logic        eng_response_done;

    modport master (
        output eng_tx_start,
        output eng_func_code,
        output eng_tx_quantity,
        output eng_tx_data,
        input  eng_tx_addr,
        input  eng_response_done
    );

    modport slave (
        input  eng_tx_start,
        input  eng_func_code,
        input  eng_tx_quantity,
        input  eng_tx_data,
        output eng_tx_addr,
        output eng_response_done
    );
endinterface

// File: rtl/modbus_resp_sched.sv
// Arbitrates normal and exception responses onto one Modbus RTU transmit engine,
// with a fixed post-frame idle gap and a watchdog abort.
module modbus_resp_sched #(
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 50000000,
    parameter int unsigned TO_W        = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       norm_req,
    input  logic [7:0]                 norm_func,
    input  logic [7:0]                 norm_qty,
    input  logic [15:0]                norm_data,
    output logic                       norm_ack,
    output logic                       norm_done,
    input  logic                       exc_req,
    input  logic [7:0]                 exc_func,
    input  logic [7:0]                 exc_code,
    output logic                       exc_ack,
    output logic                       exc_done,
    modbus_resp_sched_if.master        eng,
    output logic                       busy,
    output logic                       grant_id,
    output logic                       timeout_err
);

    localparam int unsigned GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       func_q, func_d;
    logic [7:0]       qty_q, qty_d;
    logic [7:0]       code_q, code_d;
    logic             start_q, start_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             grant_d, busy_d;
    logic             nack_d, eack_d, ndone_d, edone_d, to_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        qty_d   = qty_q;
        code_d  = code_q;
        grant_d = grant_id;
        start_d = start_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        nack_d  = 1'b0;
        eack_d  = 1'b0;
        ndone_d = 1'b0;
        edone_d = 1'b0;
        to_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (exc_req) begin
                    eack_d  = 1'b1;
                    grant_d = 1'b1;
                    func_d  = exc_func | 8'h80;
                    qty_d   = 8'd1;
                    code_d  = exc_code;
                    state_d = ST_START;
                end else if (norm_req) begin
                    nack_d  = 1'b1;
                    grant_d = 1'b0;
                    func_d  = norm_func;
                    qty_d   = norm_qty;
                    code_d  = 8'h00;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wd_d = '0;
                // An empty normal response completes without touching the engine
                if (!grant_id && qty_q == 8'd0) begin
                    ndone_d = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng.eng_response_done) begin
                    ndone_d = !grant_id;
                    edone_d = grant_id;
                    start_d = 1'b0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (wd_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    to_d    = 1'b1;
                    start_d = 1'b0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            func_q      <= '0;
            qty_q       <= '0;
            code_q      <= '0;
            start_q     <= 1'b0;
            wd_q        <= '0;
            gap_q       <= '0;
            grant_id    <= 1'b0;
            busy        <= 1'b0;
            norm_ack    <= 1'b0;
            exc_ack     <= 1'b0;
            norm_done   <= 1'b0;
            exc_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            qty_q       <= qty_d;
            code_q      <= code_d;
            start_q     <= start_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            grant_id    <= grant_d;
            busy        <= busy_d;
            norm_ack    <= nack_d;
            exc_ack     <= eack_d;
            norm_done   <= ndone_d;
            exc_done    <= edone_d;
            timeout_err <= to_d;
        end
    end

    assign eng.eng_tx_start    = start_q;
    assign eng.eng_func_code   = func_q;
    assign eng.eng_tx_quantity = qty_q;

    // Past the end of a normal frame the engine sees zeros instead of unrelated register reads
    assign eng.eng_tx_data = !busy    ? 16'h0000 :
                             grant_id ? {func_q, code_q} :
                             (eng.eng_tx_addr < qty_q) ? norm_data : 16'h0000;

endmodule

// File: tb/tb_modbus_resp_sched.sv
// Self-checking bench for modbus_resp_sched: vector table, corner-case sequences,
// and randomized requests checked against a transaction-level model.
`timescale 1ns/1ps
module tb_modbus_resp_sched;

    localparam int unsigned GAP = 4;
    localparam int unsigned TMO = 100;

    typedef struct {
        logic        is_exc;
        logic [7:0]  func;
        logic [7:0]  qty;
        logic [7:0]  code;
        logic [15:0] base;
        int          lat;
        logic        tmo;
        logic [7:0]  exp_func;
        logic [7:0]  exp_qty;
        logic [15:0] exp_data0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        norm_req, exc_req;
    logic [7:0]  norm_func, norm_qty, exc_func, exc_code;
    logic [15:0] ndata_base, norm_data;
    logic        norm_ack, norm_done, exc_ack, exc_done;
    logic        busy, grant_id, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    modbus_resp_sched_if eng ();

    // Upstream register file: word a of the current frame reads base ^ a
    assign norm_data = ndata_base ^ {8'h00, eng.eng_tx_addr};

    modbus_resp_sched #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .TO_W(32)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .norm_req    (norm_req),
        .norm_func   (norm_func),
        .norm_qty    (norm_qty),
        .norm_data   (norm_data),
        .norm_ack    (norm_ack),
        .norm_done   (norm_done),
        .exc_req     (exc_req),
        .exc_func    (exc_func),
        .exc_code    (exc_code),
        .exc_ack     (exc_ack),
        .exc_done    (exc_done),
        .eng         (eng),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", tag, what, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({norm_ack, norm_done, exc_ack, exc_done, busy, grant_id, timeout_err,
                    eng.eng_tx_start, eng.eng_func_code, eng.eng_tx_quantity, eng.eng_tx_data});
    endfunction

    task automatic post(input vec_t v);
        if (v.is_exc) begin
            exc_func = v.func;
            exc_code = v.code;
            exc_req  = 1'b1;
        end else begin
            norm_func  = v.func;
            norm_qty   = v.qty;
            ndata_base = v.base;
            norm_req   = 1'b1;
        end
    endtask

    // Wait (bounded) for an ack, check which one, release that request
    task automatic await_ack(input logic exp_exc, input string tag);
        for (int i = 0; i < 20 && !(norm_ack || exc_ack); i++) tick;
        check(tag, "ack", 64'({exc_ack, norm_ack}), exp_exc ? 64'(2'b10) : 64'(2'b01));
        check(tag, "grant_id", 64'(grant_id), 64'(exp_exc));
        if (exc_ack) exc_req = 1'b0;
        if (norm_ack) norm_req = 1'b0;
    endtask

    // Count busy cycles after completion; the engine start must stay low throughout
    task automatic gap_check(input string tag, input logic chk_to);
        int   cnt = 0;
        logic st = 1'b0;
        logic to = 1'b0;
        while (busy && cnt < 20) begin
            cnt++;
            if (eng.eng_tx_start) st = 1'b1;
            if (timeout_err) to = 1'b1;
            tick;
        end
        check(tag, "gap_len", 64'(cnt), 64'(GAP));
        check(tag, "gap_start_low", 64'(st), 64'(0));
        if (chk_to) check(tag, "gap_no_timeout", 64'(to), 64'(0));
    endtask

    task automatic serve(input vec_t v, input string tag);
        logic [7:0] a;
        int   cnt;
        logic dn;
        await_ack(v.is_exc, tag);
        tick;
        if (!v.is_exc && v.qty == 8'd0) begin
            check(tag, "zlen_done", 64'({norm_done, exc_done, eng.eng_tx_start}), 64'(3'b100));
            gap_check(tag, 1'b1);
        end else begin
            check(tag, "start", 64'(eng.eng_tx_start), 64'(1));
            check(tag, "func", 64'(eng.eng_func_code), 64'(v.exp_func));
            check(tag, "qty", 64'(eng.eng_tx_quantity), 64'(v.exp_qty));
            check(tag, "data0", 64'(eng.eng_tx_data), 64'(v.exp_data0));
            if (v.tmo) begin
                cnt = 0;
                dn  = 1'b0;
                while (!timeout_err && cnt < 200) begin
                    tick;
                    cnt++;
                    if (norm_done || exc_done) dn = 1'b1;
                end
                check(tag, "timeout_cycles", 64'(cnt), 64'(TMO));
                check(tag, "timeout_no_done", 64'(dn), 64'(0));
                check(tag, "timeout_start_low", 64'(eng.eng_tx_start), 64'(0));
                gap_check(tag, 1'b0);
            end else begin
                for (int i = 0; i < v.lat; i++) begin
                    a = v.is_exc ? 8'd0 : 8'($urandom_range(0, 32'(v.qty) - 1));
                    eng.eng_tx_addr = a;
                    #1;
                    check(tag, "data", 64'(eng.eng_tx_data),
                          64'(v.is_exc ? v.exp_data0 : (v.exp_data0 ^ {8'h00, a})));
                    tick;
                end
                eng.eng_tx_addr = 8'd0;
                eng.eng_response_done = 1'b1;
                tick;
                eng.eng_response_done = 1'b0;
                check(tag, "done", 64'({exc_done, norm_done}), v.is_exc ? 64'(2'b10) : 64'(2'b01));
                check(tag, "no_timeout", 64'(timeout_err), 64'(0));
                check(tag, "start_fall", 64'(eng.eng_tx_start), 64'(0));
                gap_check(tag, 1'b1);
            end
        end
    endtask

    vec_t tbl [6];
    vec_t v1, v2;

    initial begin
        tbl[0] = '{1'b0, 8'h03, 8'd2,   8'h00, 16'h1234, 3, 1'b0, 8'h03, 8'd2,   16'h1234};
        tbl[1] = '{1'b1, 8'h03, 8'd7,   8'h02, 16'h0000, 2, 1'b0, 8'h83, 8'd1,   16'h8302};
        tbl[2] = '{1'b0, 8'h04, 8'd125, 8'h00, 16'hABCD, 5, 1'b0, 8'h04, 8'd125, 16'hABCD};
        tbl[3] = '{1'b1, 8'h10, 8'd0,   8'h04, 16'h0000, 1, 1'b0, 8'h90, 8'd1,   16'h9004};
        tbl[4] = '{1'b1, 8'h83, 8'd9,   8'h01, 16'h0000, 0, 1'b0, 8'h83, 8'd1,   16'h8301};
        tbl[5] = '{1'b0, 8'h06, 8'd1,   8'h00, 16'h0000, 0, 1'b0, 8'h06, 8'd1,   16'h0000};

        rst_n = 1'b0;
        norm_req = 1'b0; exc_req = 1'b0;
        norm_func = 8'h00; norm_qty = 8'h00; exc_func = 8'h00; exc_code = 8'h00;
        ndata_base = 16'h0000;
        eng.eng_tx_addr = 8'd0;
        eng.eng_response_done = 1'b0;
        repeat (3) tick;
        check("reset", "outputs", outs(), 64'(0));
        rst_n = 1'b1;
        tick;

        foreach (tbl[i]) begin
            post(tbl[i]);
            serve(tbl[i], $sformatf("vec%0d", i));
        end

        // Simultaneous requests: exception first, normal held until after the gap
        v1 = '{1'b1, 8'h03, 8'd0, 8'h02, 16'h0000, 2, 1'b0, 8'h83, 8'd1, 16'h8302};
        v2 = '{1'b0, 8'h03, 8'd2, 8'h00, 16'h1234, 2, 1'b0, 8'h03, 8'd2, 16'h1234};
        post(v1);
        post(v2);
        serve(v1, "prio_exc");
        serve(v2, "prio_norm");

        // Watchdog abort, then a late completion in IDLE is ignored
        v1 = '{1'b0, 8'h03, 8'd2, 8'h00, 16'h5555, 0, 1'b1, 8'h03, 8'd2, 16'h5555};
        post(v1);
        serve(v1, "timeout");
        eng.eng_response_done = 1'b1;
        tick;
        eng.eng_response_done = 1'b0;
        tick;
        check("late_done", "outputs", 64'({norm_done, exc_done, busy, timeout_err, eng.eng_tx_start}), 64'(0));

        // Zero-length normal response
        v1 = '{1'b0, 8'h03, 8'd0, 8'h00, 16'h0000, 0, 1'b0, 8'h03, 8'd0, 16'h0000};
        post(v1);
        serve(v1, "zero_len");

        // Completion on the exact watchdog expiry cycle wins
        v1 = '{1'b1, 8'h01, 8'd0, 8'h01, 16'h0000, int'(TMO) - 1, 1'b0, 8'h81, 8'd1, 16'h8101};
        post(v1);
        serve(v1, "done_vs_expiry");

        // Asynchronous reset in the middle of a frame
        v1 = '{1'b0, 8'h03, 8'd3, 8'h00, 16'h0F0F, 0, 1'b0, 8'h03, 8'd3, 16'h0F0F};
        post(v1);
        await_ack(1'b0, "rst_mid");
        tick;
        check("rst_mid", "start", 64'(eng.eng_tx_start), 64'(1));
        repeat (5) tick;
        #2 rst_n = 1'b0;
        #1 check("rst_mid", "outputs", outs(), 64'(0));
        tick;
        rst_n = 1'b1;
        tick;
        v1 = '{1'b0, 8'h05, 8'd1, 8'h00, 16'h2468, 1, 1'b0, 8'h05, 8'd1, 16'h2468};
        post(v1);
        serve(v1, "after_rst");

        // Random traffic against the transaction-level model
        for (int t = 0; t < 40; t++) begin
            int          mode;
            logic [7:0]  f, c, q;
            logic [15:0] b;
            mode = int'($urandom_range(1, 3));
            f = 8'($urandom);
            c = 8'($urandom_range(1, 11));
            v1 = '{1'b1, f, 8'd0, c, 16'h0000, int'($urandom_range(0, 10)),
                   ($urandom_range(0, 9) == 0), f | 8'h80, 8'd1, {f | 8'h80, c}};
            f = 8'($urandom);
            q = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            b = 16'($urandom);
            v2 = '{1'b0, f, q, 8'h00, b, int'($urandom_range(0, 10)),
                   ($urandom_range(0, 9) == 0), f, q, b};
            if (mode[1]) post(v1);
            if (mode[0]) post(v2);
            if (mode[1]) serve(v1, $sformatf("rnd%0d_exc", t));
            if (mode[0]) serve(v2, $sformatf("rnd%0d_norm", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
